traffic_sensor_cond: RTL and testbench

- Input-conditioning stage directly upstream of the traffic-light FSM.
- Synchronizes and debounces the two raw street car sensors and the parade pushbutton.
- Stretches car-present indications with a minimum hold time.
- Produces the FSM's traffic inputs c_TA/c_TB and single-cycle parade set/reset pulses c_p/c_r.

---
 rtl/traffic_sensor_cond.sv | 155 +++++++++++++++
 tb/tb_traffic_sensor_cond.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_sensor_cond.sv
// Input conditioning for the traffic-light FSM: sync, debounce, hold-stretch, parade pulses.
// Optional stuck-sensor timeout is enabled by defining SENSOR_TIMEOUT_EN.
module traffic_sensor_cond #(
    parameter int unsigned DEB_CYCLES     = 4,
    parameter int unsigned HOLD_CYCLES    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic c_clk,
    input  logic c_rst,
    input  logic c_senA,
    input  logic c_senB,
    input  logic c_pbtn,
    output logic c_TA,
    output logic c_TB,
    output logic c_p,
    output logic c_r,
    output logic c_parade,
    output logic c_fault
);

    localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
    localparam int unsigned HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    localparam logic [0:0] NORMAL = 1'b0;
    localparam logic [0:0] PARADE = 1'b1;

    logic [2:0]    raw;
    logic [2:0]    meta;
    logic [2:0]    sync;
    logic [2:0]    stable;
    logic [2:0]    fall;
    logic [DW-1:0] deb_cnt [3];
    logic [HW-1:0] hold    [2];
    logic [1:0]    present;
    logic [1:0]    force_off;
    logic          btn_prev;
    logic          btn_event;
    logic [0:0]    state;

    assign raw = {c_pbtn, c_senB, c_senA};

    // Fall is flagged on the same edge stable drops, so the hold load overlaps with no gap.
    always_comb begin
        fall = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            fall[i] = (deb_cnt[i] == DW'(DEB_CYCLES)) && stable[i] && !sync[i];
        end
    end

    always_ff @(posedge c_clk or posedge c_rst) begin
        if (c_rst) begin
            meta   <= '0;
            sync   <= '0;
            stable <= '0;
            for (int unsigned i = 0; i < 3; i++) deb_cnt[i] <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
            for (int unsigned i = 0; i < 3; i++) begin
                if (deb_cnt[i] == DW'(DEB_CYCLES)) begin
                    stable[i]  <= sync[i];
                    deb_cnt[i] <= '0;
                end else if (sync[i] != stable[i]) begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

`ifdef SENSOR_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tcnt [2];
    logic [1:0]    fault;
    logic [1:0]    fault_set;

    always_comb begin
        fault_set = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            fault_set[i] = stable[i] && !fault[i] && (tcnt[i] == TW'(TIMEOUT_CYCLES - 1));
        end
    end

    always_ff @(posedge c_clk or posedge c_rst) begin
        if (c_rst) begin
            fault <= '0;
            for (int unsigned i = 0; i < 2; i++) tcnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (!stable[i]) begin
                    tcnt[i]  <= '0;
                    fault[i] <= 1'b0;
                end else if (fault_set[i]) begin
                    tcnt[i]  <= '0;
                    fault[i] <= 1'b1;
                end else if (!fault[i]) begin
                    tcnt[i] <= tcnt[i] + 1'b1;
                end
            end
        end
    end

    // Forcing uses the set condition too, so c_TA drops on the same edge c_fault rises.
    assign force_off = fault | fault_set;
    assign c_fault   = |fault;
`else
    logic unused_cfg;

    assign unused_cfg = |TIMEOUT_CYCLES;
    assign force_off  = '0;
    assign c_fault    = 1'b0;
`endif

    always_ff @(posedge c_clk or posedge c_rst) begin
        if (c_rst) begin
            present <= '0;
            for (int unsigned i = 0; i < 2; i++) hold[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (fall[i] && !force_off[i]) begin
                    hold[i] <= HW'(HOLD_CYCLES);
                end else if (stable[i] || force_off[i]) begin
                    hold[i] <= '0;
                end else if (hold[i] != '0) begin
                    hold[i] <= hold[i] - 1'b1;
                end
                present[i] <= (stable[i] | (hold[i] != '0)) & ~force_off[i];
            end
        end
    end

    assign c_TA = present[0];
    assign c_TB = present[1];

    assign btn_event = stable[2] & ~btn_prev;

    always_ff @(posedge c_clk or posedge c_rst) begin
        if (c_rst) begin
            btn_prev <= 1'b0;
            state    <= NORMAL;
            c_p      <= 1'b0;
            c_r      <= 1'b0;
        end else begin
            btn_prev <= stable[2];
            c_p      <= btn_event && (state == NORMAL);
            c_r      <= btn_event && (state == PARADE);
            if (btn_event) state <= (state == NORMAL) ? PARADE : NORMAL;
        end
    end

    assign c_parade = (state == PARADE);

endmodule

// File: tb/tb_traffic_sensor_cond.sv
// Scoreboard bench for traffic_sensor_cond: expected output vectors are queued per cycle as stimulus is driven.
module tb_traffic_sensor_cond;

    logic c_clk = 1'b0;
    logic c_rst;
    logic c_senA;
    logic c_senB;
    logic c_pbtn;
    logic c_TA;
    logic c_TB;
    logic c_p;
    logic c_r;
    logic c_parade;
    logic c_fault;

    logic [5:0] obs;
    logic [5:0] exp_q [$];
    int unsigned vectors;
    int unsigned miscompares;

    traffic_sensor_cond #(
        .DEB_CYCLES(4),
        .HOLD_CYCLES(8),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .c_clk(c_clk),
        .c_rst(c_rst),
        .c_senA(c_senA),
        .c_senB(c_senB),
        .c_pbtn(c_pbtn),
        .c_TA(c_TA),
        .c_TB(c_TB),
        .c_p(c_p),
        .c_r(c_r),
        .c_parade(c_parade),
        .c_fault(c_fault)
    );

    always #5 c_clk = ~c_clk;

    // Bit order: TA, TB, p, r, parade, fault
    assign obs = {c_TA, c_TB, c_p, c_r, c_parade, c_fault};

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic apply_reset();
        c_senA = 1'b0;
        c_senB = 1'b0;
        c_pbtn = 1'b0;
        c_rst  = 1'b1;
        tick();
        tick();
        c_rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] e;
        logic [5:0] got;
        apply_reset();
        vectors++;
        if (obs !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_state got=%b exp=%b", obs, 6'b0);
        end
        c_senA = 1'b1;
        for (int k = 0; k < 12; k++) begin
            e = '0;
            e[5] = (k >= 7);
            exp_q.push_back(e);
            tick();
            got = exp_q.pop_front();
            vectors++;
            if (obs !== got) begin
                miscompares++;
                $display("FAIL reset_latency k=%0d got=%b exp=%b", k, obs, got);
            end
        end
        #3;
        c_rst = 1'b1;
        #1;
        vectors++;
        if (obs !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_async got=%b exp=%b", obs, 6'b0);
        end
        tick();
        tick();
        c_rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            e = '0;
            e[5] = (k >= 7);
            exp_q.push_back(e);
            tick();
            got = exp_q.pop_front();
            vectors++;
            if (obs !== got) begin
                miscompares++;
                $display("FAIL reset_restart k=%0d got=%b exp=%b", k, obs, got);
            end
        end
    endtask

    task automatic test_glitch();
        logic [5:0] got;
        apply_reset();
        for (int k = 0; k < 20; k++) begin
            c_senA = (k < 3);
            exp_q.push_back(6'b0);
            tick();
            got = exp_q.pop_front();
            vectors++;
            if (obs !== got) begin
                miscompares++;
                $display("FAIL glitch k=%0d got=%b exp=%b", k, obs, got);
            end
        end
    endtask

    task automatic test_hold();
        logic [5:0] e;
        logic [5:0] got;
        apply_reset();
        for (int k = 0; k < 31; k++) begin
            c_senB = (k < 10);
            e = '0;
            e[4] = (k >= 7) && (k < 25);
            exp_q.push_back(e);
            tick();
            got = exp_q.pop_front();
            vectors++;
            if (obs !== got) begin
                miscompares++;
                $display("FAIL hold k=%0d got=%b exp=%b", k, obs, got);
            end
        end
    endtask

    task automatic test_hold_reassert();
        logic [5:0] e;
        logic [5:0] got;
        apply_reset();
        for (int k = 0; k < 36; k++) begin
            c_senB = (k < 10) || (k >= 15);
            e = '0;
            e[4] = (k >= 7);
            exp_q.push_back(e);
            tick();
            got = exp_q.pop_front();
            vectors++;
            if (obs !== got) begin
                miscompares++;
                $display("FAIL hold_reassert k=%0d got=%b exp=%b", k, obs, got);
            end
        end
    endtask

    task automatic test_parade();
        logic [5:0] e;
        logic [5:0] got;
        apply_reset();
        for (int ph = 0; ph < 2; ph++) begin
            for (int k = 0; k < 40; k++) begin
                c_pbtn = (k < 20);
                e = '0;
                e[3] = (ph == 0) && (k == 7);
                e[2] = (ph == 1) && (k == 7);
                e[1] = (ph == 0) ? (k >= 7) : (k < 7);
                exp_q.push_back(e);
                tick();
                got = exp_q.pop_front();
                vectors++;
                if (obs !== got) begin
                    miscompares++;
                    $display("FAIL parade ph=%0d k=%0d got=%b exp=%b", ph, k, obs, got);
                end
            end
        end
    endtask

    task automatic test_bounce();
        logic [5:0] got;
        apply_reset();
        for (int k = 0; k < 40; k++) begin
            c_pbtn = (k < 12) ? (k % 2 == 0) : 1'b0;
            exp_q.push_back(6'b0);
            tick();
            got = exp_q.pop_front();
            vectors++;
            if (obs !== got) begin
                miscompares++;
                $display("FAIL bounce k=%0d got=%b exp=%b", k, obs, got);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] e;
        logic [5:0] got;
        apply_reset();
        for (int k = 0; k < 41; k++) begin
            c_senA = (k < 10);
            c_senB = (k < 20);
            e = '0;
            e[5] = (k >= 7) && (k < 25);
            e[4] = (k >= 7) && (k < 35);
            exp_q.push_back(e);
            tick();
            got = exp_q.pop_front();
            vectors++;
            if (obs !== got) begin
                miscompares++;
                $display("FAIL both_streets k=%0d got=%b exp=%b", k, obs, got);
            end
        end
    endtask

`ifdef SENSOR_TIMEOUT_EN
    task automatic test_timeout();
        logic [5:0] e;
        logic [5:0] got;
        apply_reset();
        for (int k = 0; k < 115; k++) begin
            c_senA = (k < 100);
            e = '0;
            e[5] = (k >= 7) && (k < 70);
            e[0] = (k >= 70) && (k < 107);
            exp_q.push_back(e);
            tick();
            got = exp_q.pop_front();
            vectors++;
            if (obs !== got) begin
                miscompares++;
                $display("FAIL timeout k=%0d got=%b exp=%b", k, obs, got);
            end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        c_rst  = 1'b1;
        c_senA = 1'b0;
        c_senB = 1'b0;
        c_pbtn = 1'b0;
        test_reset();
        test_glitch();
        test_hold();
        test_hold_reassert();
        test_parade();
        test_bounce();
        test_back_to_back();
`ifdef SENSOR_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
